// File: rtl/uart_rx_param.sv
// Oversampling UART receiver with majority-vote bit decisions, optional parity,
// configurable stop bits, an idle-arming guard and a valid/ready output register.
module uart_rx_param #(
  parameter int P_DATA_BITS  = 8,
  parameter int P_OVERSAMPLE = 16,
  parameter int P_PARITY     = 0,
  parameter int P_STOP_BITS  = 1,
  parameter int P_IDLE_TH    = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   baud_tick,
  input  logic                   serial_in,
  output logic [P_DATA_BITS-1:0] m_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic                   frame_err,
  output logic                   parity_err,
  output logic                   overrun_err,
  output logic                   busy
);

  localparam int CNT_MAX = (P_OVERSAMPLE > P_IDLE_TH) ? P_OVERSAMPLE : P_IDLE_TH;
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam int BW = $clog2(P_DATA_BITS + 1);
  localparam int SW = $clog2(P_STOP_BITS + 1);

  localparam logic [CW-1:0] IDX_A     = CW'(P_OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] IDX_B     = CW'(P_OVERSAMPLE / 2);
  localparam logic [CW-1:0] IDX_C     = CW'(P_OVERSAMPLE / 2 + 1);
  localparam logic [CW-1:0] IDX_END   = CW'(P_OVERSAMPLE - 1);
  localparam logic [CW-1:0] IDLE_LAST = CW'(P_IDLE_TH - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(P_DATA_BITS - 1);
  localparam logic [SW-1:0] STOP_LAST = SW'(P_STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_UNARMED, S_ARMED, S_START, S_DATA, S_PARITY, S_STOP
  } state_t;

  state_t                 state_q, state_d;
  logic                   sync1_q, sync2_q;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
  logic [SW-1:0]          stop_cnt_q, stop_cnt_d;
  logic [1:0]             samp_q, samp_d;
  logic [P_DATA_BITS-1:0] shift_q, shift_d;
  logic                   par_q, par_d;
  logic [P_DATA_BITS-1:0] data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   ferr_q, ferr_d;
  logic                   perr_q, perr_d;
  logic                   oerr_q, oerr_d;

  logic line, vote, par_x, par_ok, deliver;

  assign line  = sync2_q;
  // Third sample is the live line; the first two were captured on earlier ticks.
  assign vote  = (samp_q[0] & samp_q[1]) | (samp_q[0] & line) | (samp_q[1] & line);
  assign par_x = ^{shift_q, par_q};
  assign par_ok = (P_PARITY == 1) ? par_x : (P_PARITY == 2) ? !par_x : 1'b1;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    samp_d     = samp_q;
    shift_d    = shift_q;
    par_d      = par_q;
    data_d     = data_q;
    valid_d    = valid_q;
    ferr_d     = 1'b0;
    perr_d     = 1'b0;
    oerr_d     = 1'b0;
    deliver    = 1'b0;

    if (valid_q && m_ready) valid_d = 1'b0;

    if (baud_tick) begin
      if (cnt_q == IDX_A) samp_d[0] = line;
      if (cnt_q == IDX_B) samp_d[1] = line;
      case (state_q)
        S_UNARMED: begin
          if (!line) begin
            cnt_d = '0;
          end else if (cnt_q == IDLE_LAST) begin
            state_d = S_ARMED;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_ARMED: begin
          if (!line) begin
            state_d = S_START;
            cnt_d   = '0;
          end
        end
        S_START: begin
          cnt_d = cnt_q + 1'b1;
          // A high vote is a glitch, not a start bit; otherwise ride out the bit.
          if (cnt_q == IDX_C && vote) begin
            state_d = S_ARMED;
            cnt_d   = '0;
          end else if (cnt_q == IDX_END) begin
            state_d   = S_DATA;
            cnt_d     = '0;
            bit_cnt_d = '0;
          end
        end
        S_DATA: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == IDX_C) shift_d = {vote, shift_q[P_DATA_BITS-1:1]};
          if (cnt_q == IDX_END) begin
            cnt_d = '0;
            if (bit_cnt_q == BIT_LAST) begin
              bit_cnt_d  = '0;
              stop_cnt_d = '0;
              state_d    = (P_PARITY != 0) ? S_PARITY : S_STOP;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
        end
        S_PARITY: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == IDX_C) par_d = vote;
          if (cnt_q == IDX_END) begin
            state_d    = S_STOP;
            cnt_d      = '0;
            stop_cnt_d = '0;
          end
        end
        S_STOP: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == IDX_C) begin
            if (!vote) begin
              ferr_d  = 1'b1;
              state_d = S_UNARMED;
              cnt_d   = '0;
            end else if (stop_cnt_q == STOP_LAST) begin
              // Re-arm at the vote tick so a back-to-back start edge is caught.
              state_d = S_ARMED;
              cnt_d   = '0;
              if (!par_ok) perr_d = 1'b1;
              else         deliver = 1'b1;
            end
          end else if (cnt_q == IDX_END) begin
            cnt_d      = '0;
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = S_UNARMED;
          cnt_d   = '0;
        end
      endcase
    end

    if (deliver) begin
      if (valid_q && !m_ready) begin
        oerr_d = 1'b1;
      end else begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_UNARMED;
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      cnt_q      <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= '0;
      samp_q     <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
      perr_q     <= 1'b0;
      oerr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= serial_in;
      sync2_q    <= sync1_q;
      cnt_q      <= cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      samp_q     <= samp_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
      perr_q     <= perr_d;
      oerr_q     <= oerr_d;
    end
  end

  assign m_data      = data_q;
  assign m_valid     = valid_q;
  assign frame_err   = ferr_q;
  assign parity_err  = perr_q;
  assign overrun_err = oerr_q;
  assign busy        = (state_q != S_UNARMED) && (state_q != S_ARMED);

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: a default instance (A) and an even-parity instance (B)
// driven by a directed vector table, hand-written corner sequences and random frames.
module tb_uart_rx_param;

  localparam int OS = 16;

  logic clk = 1'b0;
  logic reset, baud_tick;
  logic rx_a, rx_b, rdy_a, rdy_b;
  logic [7:0] m_data_a, m_data_b;
  logic m_valid_a, m_valid_b, fe_o_a, fe_o_b, pe_o_a, pe_o_b, oe_o_a, oe_o_b, busy_a, busy_b;

  always #5 clk = ~clk;

  uart_rx_param u_dut_a (
    .clk(clk), .reset(reset), .baud_tick(baud_tick), .serial_in(rx_a),
    .m_data(m_data_a), .m_valid(m_valid_a), .m_ready(rdy_a),
    .frame_err(fe_o_a), .parity_err(pe_o_a), .overrun_err(oe_o_a), .busy(busy_a)
  );

  uart_rx_param #(.P_PARITY(2)) u_dut_b (
    .clk(clk), .reset(reset), .baud_tick(baud_tick), .serial_in(rx_b),
    .m_data(m_data_b), .m_valid(m_valid_b), .m_ready(rdy_b),
    .frame_err(fe_o_b), .parity_err(pe_o_b), .overrun_err(oe_o_b), .busy(busy_b)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pulse counters, accepted-word queues, delivery timing.
  int fe_a = 0, pe_a = 0, oe_a = 0, fe_b = 0, pe_b = 0, oe_b = 0, busy_clks_a = 0;
  logic [7:0] got_a[$], got_b[$];
  logic prev_valid_a = 1'b0, prev_valid_b = 1'b0, prev_tick = 1'b0;

  always @(negedge clk) begin
    #1;
    if (fe_o_a) fe_a++;
    if (pe_o_a) pe_a++;
    if (oe_o_a) oe_a++;
    if (fe_o_b) fe_b++;
    if (pe_o_b) pe_b++;
    if (oe_o_b) oe_b++;
    if (busy_a) busy_clks_a++;
    if (m_valid_a && rdy_a) got_a.push_back(m_data_a);
    if (m_valid_b && rdy_b) got_b.push_back(m_data_b);
    // A word must appear exactly one clk after a vote tick.
    if (m_valid_a && !prev_valid_a) chk("valid_rise_after_tick_a", {31'd0, prev_tick}, 32'd1);
    if (m_valid_b && !prev_valid_b) chk("valid_rise_after_tick_b", {31'd0, prev_tick}, 32'd1);
    prev_valid_a = m_valid_a;
    prev_valid_b = m_valid_b;
    prev_tick    = baud_tick;
  end

  task automatic do_tick();
    @(negedge clk); baud_tick = 1'b1;
    @(negedge clk); baud_tick = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic set_line(input bit sel, input logic v);
    if (sel) rx_b = v;
    else     rx_a = v;
  endtask

  task automatic idle(input int n);
    rx_a = 1'b1;
    rx_b = 1'b1;
    for (int i = 0; i < n; i++) do_tick();
  endtask

  // Frame: start, 8 data LSB first, optional parity (par >= 0), one stop bit.
  // glitch_bit >= 0 inverts one tick in the middle of that frame bit.
  task automatic send_frame(input bit sel, input logic [7:0] d, input int par,
                            input bit stop_low, input int glitch_bit);
    logic bits [11];
    int nb;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1 + i] = d[i];
    nb = 9;
    if (par >= 0) begin
      bits[nb] = par[0];
      nb++;
    end
    bits[nb] = !stop_low;
    nb++;
    $display("frame dut=%s data=%02h par=%0d stop_low=%0d glitch=%0d",
             sel ? "B" : "A", d, par, stop_low, glitch_bit);
    for (int b = 0; b < nb; b++) begin
      for (int t = 0; t < OS; t++) begin
        set_line(sel, (b == glitch_bit && t == OS / 2) ? !bits[b] : bits[b]);
        do_tick();
      end
    end
    set_line(sel, 1'b1);
  endtask

  task automatic consume(input bit sel);
    @(negedge clk);
    if (sel) rdy_b = 1'b1; else rdy_a = 1'b1;
    @(negedge clk);
    rdy_a = 1'b0;
    rdy_b = 1'b0;
    @(negedge clk);
  endtask

  typedef struct {
    bit         sel;
    logic [7:0] data;
    int         par;
    bit         stop_low;
    bit         exp_valid;
    logic [7:0] exp_data;
    int         exp_fe;
    int         exp_pe;
  } vec_t;

  vec_t vecs [9];
  int fe0, pe0, oe0, bc0, gsz;
  logic [7:0] rd, exp_w;
  bit sel;
  int par_bit, gl;
  bit par_good;

  initial begin
    vecs[0] = '{1'b0, 8'hA5, -1, 1'b0, 1'b1, 8'hA5, 0, 0};
    vecs[1] = '{1'b0, 8'h55, -1, 1'b1, 1'b0, 8'h00, 1, 0};
    vecs[2] = '{1'b1, 8'h03,  1, 1'b0, 1'b0, 8'h00, 0, 1};
    vecs[3] = '{1'b1, 8'h03,  0, 1'b0, 1'b1, 8'h03, 0, 0};
    vecs[4] = '{1'b1, 8'h7F,  0, 1'b0, 1'b0, 8'h00, 0, 1};
    vecs[5] = '{1'b1, 8'h80,  1, 1'b0, 1'b1, 8'h80, 0, 0};
    vecs[6] = '{1'b1, 8'h0F,  1, 1'b1, 1'b0, 8'h00, 1, 0};
    vecs[7] = '{1'b0, 8'hFF, -1, 1'b0, 1'b1, 8'hFF, 0, 0};
    vecs[8] = '{1'b0, 8'h00, -1, 1'b0, 1'b1, 8'h00, 0, 0};

    reset = 1'b1; baud_tick = 1'b0; rx_a = 1'b1; rx_b = 1'b1; rdy_a = 1'b0; rdy_b = 1'b0;
    repeat (4) @(negedge clk);
    chk("reset_valid", {31'd0, m_valid_a}, 32'd0);
    chk("reset_data", {24'd0, m_data_a}, 32'd0);
    chk("reset_busy", {31'd0, busy_a}, 32'd0);
    chk("reset_errs", {29'd0, fe_o_a, pe_o_a, oe_o_a}, 32'd0);
    reset = 1'b0;

    // Directed vector table.
    for (int v = 0; v < 9; v++) begin
      idle(20);
      fe0 = vecs[v].sel ? fe_b : fe_a;
      pe0 = vecs[v].sel ? pe_b : pe_a;
      oe0 = vecs[v].sel ? oe_b : oe_a;
      send_frame(vecs[v].sel, vecs[v].data, vecs[v].par, vecs[v].stop_low, -1);
      idle(10);
      chk($sformatf("v%0d_valid", v), {31'd0, vecs[v].sel ? m_valid_b : m_valid_a},
          {31'd0, vecs[v].exp_valid});
      if (vecs[v].exp_valid)
        chk($sformatf("v%0d_data", v), {24'd0, vecs[v].sel ? m_data_b : m_data_a},
            {24'd0, vecs[v].exp_data});
      chk($sformatf("v%0d_frame_err", v), (vecs[v].sel ? fe_b : fe_a) - fe0, vecs[v].exp_fe);
      chk($sformatf("v%0d_parity_err", v), (vecs[v].sel ? pe_b : pe_a) - pe0, vecs[v].exp_pe);
      chk($sformatf("v%0d_overrun", v), (vecs[v].sel ? oe_b : oe_a) - oe0, 0);
      chk($sformatf("v%0d_busy", v), {31'd0, vecs[v].sel ? busy_b : busy_a}, 32'd0);
      if (vecs[v].exp_valid) begin
        consume(vecs[v].sel);
        chk($sformatf("v%0d_valid_cleared", v), {31'd0, vecs[v].sel ? m_valid_b : m_valid_a}, 32'd0);
      end
      got_a.delete();
      got_b.delete();
    end

    // Frame error, then a start before the idle threshold must be ignored.
    idle(20);
    fe0 = fe_a;
    send_frame(1'b0, 8'h55, -1, 1'b1, -1);
    idle(5);
    send_frame(1'b0, 8'h00, -1, 1'b0, -1);
    idle(2);
    chk("ferr_pulse", fe_a - fe0, 1);
    chk("ferr_no_valid", {31'd0, m_valid_a}, 32'd0);
    chk("ferr_busy", {31'd0, busy_a}, 32'd0);
    idle(20);
    send_frame(1'b0, 8'h5A, -1, 1'b0, -1);
    idle(2);
    chk("rearm_data", {24'd0, m_data_a}, 32'h5A);
    consume(1'b0);
    got_a.delete();

    // Overrun: two back-to-back frames with no consumer.
    idle(20);
    oe0 = oe_a;
    send_frame(1'b0, 8'h11, -1, 1'b0, -1);
    chk("ovr_first_no_err", oe_a - oe0, 0);
    send_frame(1'b0, 8'h22, -1, 1'b0, -1);
    idle(2);
    chk("ovr_pulse", oe_a - oe0, 1);
    chk("ovr_valid", {31'd0, m_valid_a}, 32'd1);
    chk("ovr_data_kept", {24'd0, m_data_a}, 32'h11);
    consume(1'b0);
    chk("ovr_only_one_word", got_a.size(), 1);
    got_a.delete();

    // Short low glitch on the idle line: brief start check only.
    idle(20);
    bc0 = busy_clks_a;
    fe0 = fe_a;
    rx_a = 1'b0;
    for (int i = 0; i < 4; i++) do_tick();
    idle(20);
    chk("glitch_busy_seen", {31'd0, (busy_clks_a - bc0) > 0}, 32'd1);
    chk("glitch_busy_short", {31'd0, (busy_clks_a - bc0) <= (OS / 2 + 3) * 4}, 32'd1);
    chk("glitch_no_valid", {31'd0, m_valid_a}, 32'd0);
    chk("glitch_no_ferr", fe_a - fe0, 0);
    send_frame(1'b0, 8'hFF, -1, 1'b0, 4);
    idle(2);
    chk("centre_glitch_data", {24'd0, m_data_a}, 32'hFF);
    consume(1'b0);
    got_a.delete();

    // Reset in the middle of the data bits with a held word present.
    idle(20);
    send_frame(1'b0, 8'h77, -1, 1'b0, -1);
    idle(20);
    for (int t = 0; t < OS * 3 + OS / 2; t++) begin
      rx_a = (t >= OS && t < 2 * OS) ? 1'b1 : 1'b0;
      do_tick();
    end
    chk("mid_frame_busy", {31'd0, busy_a}, 32'd1);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); #1;
    chk("rst_mid_valid", {31'd0, m_valid_a}, 32'd0);
    chk("rst_mid_data", {24'd0, m_data_a}, 32'd0);
    chk("rst_mid_busy", {31'd0, busy_a}, 32'd0);
    reset = 1'b0;
    got_a.delete();
    got_b.delete();
    idle(20);
    send_frame(1'b0, 8'h3C, -1, 1'b0, -1);
    idle(2);
    chk("post_reset_data", {24'd0, m_data_a}, 32'h3C);
    chk("post_reset_valid", {31'd0, m_valid_a}, 32'd1);
    consume(1'b0);
    got_a.delete();

    // Random frames against the reference model (consumers always ready).
    rdy_a = 1'b1;
    rdy_b = 1'b1;
    for (int n = 0; n < 24; n++) begin
      idle($urandom_range(0, 6));
      sel  = $urandom_range(0, 1);
      rd   = 8'($urandom);
      pe0  = sel ? pe_b : pe_a;
      if (sel) begin
        // Even parity: data ones plus parity bit must be even.
        par_good = ($urandom_range(0, 3) != 0);
        par_bit  = (^rd) ^ (par_good ? 1 : 0) ^ 1;
        par_bit  = par_good ? int'(^rd) : int'(!(^rd));
        gl = -1;
      end else begin
        par_good = 1'b1;
        par_bit  = -1;
        gl = ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, 8)) : -1;
      end
      send_frame(sel, rd, par_bit, 1'b0, gl);
      idle(1);
      gsz = sel ? got_b.size() : got_a.size();
      if (par_good) begin
        chk($sformatf("rnd%0d_words", n), gsz, 1);
        if (gsz == 1) begin
          exp_w = rd;
          chk($sformatf("rnd%0d_data", n), {24'd0, sel ? got_b[0] : got_a[0]}, {24'd0, exp_w});
        end
      end else begin
        chk($sformatf("rnd%0d_words", n), gsz, 0);
        chk($sformatf("rnd%0d_parity_err", n), (sel ? pe_b : pe_a) - pe0, 1);
      end
      got_a.delete();
      got_b.delete();
    end
    rdy_a = 1'b0;
    rdy_b = 1'b0;
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
